axi2mem_rd_burst_splitter: RTL and testbench

- Front end of the axi2mem read path, directly upstream of the TCDM unit's two read-command lanes.
- Accepts one AXI AR burst at a time and walks it beat by beat.
- For each 64-bit beat it issues one 32-bit word command per lane: lane0 gets the low word, lane1 the high word.
- Each command carries the burst ID and a last flag, sent on the trans_rd_* handshake that feeds the per-lane read queues.

---
 rtl/axi2mem_pkg.sv | 30 +++
 rtl/axi2mem_addr_gen.sv | 47 ++++
 rtl/axi2mem_rd_burst_splitter.sv | 171 +++++++++++++++++
 tb/tb_axi2mem_rd_burst_splitter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi2mem_pkg.sv
// Shared types and constants for the axi2mem read/write front end.
//   burst_t          : AXI AxBURST encoding
//   rd_split_state_t : read burst splitter FSM states
//   DATA_BYTES       : AXI data bus width in bytes (64-bit bus)
//   LANE_BYTES       : TCDM lane word width in bytes (32-bit lanes)
package axi2mem_pkg;

    localparam int unsigned DATA_BYTES = 8;
    localparam int unsigned LANE_BYTES = 4;
    localparam int unsigned NUM_LANES  = 2;
    localparam int unsigned SIZE_EFF_W = 2;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_split_state_t;

    // The data bus is 64-bit, so any wider beat size collapses to 8 bytes.
    function automatic logic [SIZE_EFF_W-1:0] clamp_size(input logic [2:0] size);
        return (size > 3'd3) ? 2'd3 : size[1:0];
    endfunction

endpackage

// File: rtl/axi2mem_addr_gen.sv
// Combinational AXI next-beat address generator (FIXED / INCR / WRAP).
//   addr_i        : current beat byte address
//   len_i         : burst length minus one
//   size_i        : effective log2 bytes per beat (0..3)
//   burst_i       : burst type; RSVD and WRAP with an illegal length act as INCR
//   next_addr_c_o : byte address of the following beat
module axi2mem_addr_gen
    import axi2mem_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_LEN_WIDTH  = 8
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [AXI_LEN_WIDTH-1:0]  len_i,
    input  logic [SIZE_EFF_W-1:0]     size_i,
    input  burst_t                    burst_i,
    output logic [AXI_ADDR_WIDTH-1:0] next_addr_c_o
);

    localparam int unsigned AW = AXI_ADDR_WIDTH;
    localparam int unsigned LW = AXI_LEN_WIDTH;

    logic [AW-1:0] incr;
    logic [AW-1:0] sum;
    logic [AW-1:0] wrap_mask;
    logic          wrap_ok;

    always_comb begin
        incr      = AW'(1) << size_i;
        sum       = addr_i + incr;
        wrap_mask = ((AW'(len_i) + AW'(1)) << size_i) - AW'(1);
        wrap_ok   = (len_i == LW'(1)) || (len_i == LW'(3)) ||
                    (len_i == LW'(7)) || (len_i == LW'(15));

        next_addr_c_o = sum;
        case (burst_i)
            BURST_FIXED: next_addr_c_o = addr_i;
            BURST_WRAP: begin
                if (wrap_ok) begin
                    next_addr_c_o = (addr_i & ~wrap_mask) | (sum & wrap_mask);
                end
            end
            default: next_addr_c_o = sum;
        endcase
    end

endmodule

// File: rtl/axi2mem_rd_burst_splitter.sv
// Splits one AXI AR burst into per-beat 32-bit word commands on two TCDM lanes.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   ar_*                  : AXI read address channel (one burst at a time)
//   trans_rd_req_o/gnt_i  : per-lane command handshake
//   trans_rd_id_o/add_o   : per-lane burst ID and word address (lane0 low word)
//   trans_rd_last_o       : last beat of the burst, identical on both lanes
module axi2mem_rd_burst_splitter
    import axi2mem_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_LEN_WIDTH  = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     ar_valid_i,
    output logic                                     ar_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]                  ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]                ar_addr_i,
    input  logic [AXI_LEN_WIDTH-1:0]                 ar_len_i,
    input  logic [2:0]                               ar_size_i,
    input  logic [1:0]                               ar_burst_i,
    output logic [NUM_LANES-1:0][AXI_ID_WIDTH-1:0]   trans_rd_id_o,
    output logic [NUM_LANES-1:0][AXI_ADDR_WIDTH-1:0] trans_rd_add_o,
    output logic [NUM_LANES-1:0]                     trans_rd_last_o,
    output logic [NUM_LANES-1:0]                     trans_rd_req_o,
    input  logic [NUM_LANES-1:0]                     trans_rd_gnt_i
);

    localparam int unsigned AW = AXI_ADDR_WIDTH;
    localparam int unsigned IW = AXI_ID_WIDTH;
    localparam int unsigned LW = AXI_LEN_WIDTH;

    rd_split_state_t                state_q, state_d;
    logic                           ar_ready_q, ar_ready_d;
    logic [IW-1:0]                  id_q, id_d;
    logic [AW-1:0]                  addr_q, addr_d;
    logic [LW-1:0]                  len_q, len_d;
    logic [SIZE_EFF_W-1:0]          size_q, size_d;
    burst_t                         burst_q, burst_d;
    logic [LW-1:0]                  cnt_q, cnt_d;
    logic [NUM_LANES-1:0]           done_q, done_d;
    logic [NUM_LANES-1:0]           req_q, req_d;
    logic [NUM_LANES-1:0][AW-1:0]   add_q, add_d;
    logic                           last_q, last_d;

    logic [AW-1:0]                  next_addr;
    logic [LW-1:0]                  cnt_nxt;
    logic [NUM_LANES-1:0]           gnt_hit;
    logic                           beat_done;

    // Lane0 reads the low word of the 64-bit beat, lane1 the high word.
    function automatic logic [NUM_LANES-1:0][AW-1:0] lane_addrs(input logic [AW-1:0] a);
        logic [NUM_LANES-1:0][AW-1:0] res;
        res[0] = a & ~AW'(DATA_BYTES - 1);
        res[1] = res[0] + AW'(LANE_BYTES);
        return res;
    endfunction

    axi2mem_addr_gen #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .AXI_LEN_WIDTH  (AXI_LEN_WIDTH)
    ) u_addr_gen (
        .addr_i        (addr_q),
        .len_i         (len_q),
        .size_i        (size_q),
        .burst_i       (burst_q),
        .next_addr_c_o (next_addr)
    );

    // Next-state, burst bookkeeping and lane handshake.
    always_comb begin
        state_d    = state_q;
        ar_ready_d = ar_ready_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        req_d      = req_q;
        add_d      = add_q;
        last_d     = last_q;

        cnt_nxt   = cnt_q + LW'(1);
        gnt_hit   = req_q & trans_rd_gnt_i;
        // Counting same-cycle grants lets both-granted beats advance back to back.
        beat_done = &(done_q | gnt_hit);

        unique case (state_q)
            RD_IDLE: begin
                if (ar_valid_i && ar_ready_q) begin
                    state_d    = RD_BURST;
                    ar_ready_d = 1'b0;
                    id_d       = ar_id_i;
                    addr_d     = ar_addr_i;
                    len_d      = ar_len_i;
                    size_d     = clamp_size(ar_size_i);
                    burst_d    = burst_t'(ar_burst_i);
                    cnt_d      = '0;
                    done_d     = '0;
                    req_d      = '1;
                    add_d      = lane_addrs(ar_addr_i);
                    last_d     = (ar_len_i == '0);
                end
            end
            RD_BURST: begin
                if (beat_done) begin
                    done_d = '0;
                    if (cnt_q == len_q) begin
                        state_d    = RD_IDLE;
                        ar_ready_d = 1'b1;
                        req_d      = '0;
                        last_d     = 1'b0;
                    end else begin
                        cnt_d  = cnt_nxt;
                        addr_d = next_addr;
                        add_d  = lane_addrs(next_addr);
                        last_d = (cnt_nxt == len_q);
                        req_d  = '1;
                    end
                end else begin
                    done_d = done_q | gnt_hit;
                    req_d  = req_q & ~trans_rd_gnt_i;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RD_IDLE;
            ar_ready_q <= 1'b1;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= BURST_FIXED;
            cnt_q      <= '0;
            done_q     <= '0;
            req_q      <= '0;
            add_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ar_ready_q <= ar_ready_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            req_q      <= req_d;
            add_q      <= add_d;
            last_q     <= last_d;
        end
    end

    assign ar_ready_o      = ar_ready_q;
    assign trans_rd_req_o  = req_q;
    assign trans_rd_add_o  = add_q;
    assign trans_rd_id_o   = {id_q, id_q};
    assign trans_rd_last_o = {last_q, last_q};

endmodule

// File: tb/tb_axi2mem_rd_burst_splitter.sv
// Directed bench for axi2mem_rd_burst_splitter.
module tb_axi2mem_rd_burst_splitter;

    logic             clk;
    logic             rst;
    logic             ar_valid;
    logic             ar_ready;
    logic [5:0]       ar_id;
    logic [31:0]      ar_addr;
    logic [7:0]       ar_len;
    logic [2:0]       ar_size;
    logic [1:0]       ar_burst;
    logic [1:0][5:0]  rd_id;
    logic [1:0][31:0] rd_add;
    logic [1:0]       rd_last;
    logic [1:0]       rd_req;
    logic [1:0]       rd_gnt;

    int n_cmp = 0;
    int n_err = 0;
    int g0_cnt = 0;
    int g1_cnt = 0;

    axi2mem_rd_burst_splitter #(
        .AXI_ADDR_WIDTH (32),
        .AXI_ID_WIDTH   (6),
        .AXI_LEN_WIDTH  (8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ar_valid_i      (ar_valid),
        .ar_ready_o      (ar_ready),
        .ar_id_i         (ar_id),
        .ar_addr_i       (ar_addr),
        .ar_len_i        (ar_len),
        .ar_size_i       (ar_size),
        .ar_burst_i      (ar_burst),
        .trans_rd_id_o   (rd_id),
        .trans_rd_add_o  (rd_add),
        .trans_rd_last_o (rd_last),
        .trans_rd_req_o  (rd_req),
        .trans_rd_gnt_i  (rd_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted lane commands for duplicate/loss checks.
    always @(posedge clk) begin
        if (!rst && rd_req[0] && rd_gnt[0]) g0_cnt++;
        if (!rst && rd_req[1] && rd_gnt[1]) g1_cnt++;
    end

    // Issues one AR; returns at the negedge where the first beat is visible.
    task automatic do_ar(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        @(negedge clk);
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        @(negedge clk);
        ar_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (ar_ready !== 1'b1) begin n_err++; $display("FAIL reset_ar_ready got %b want 1", ar_ready); end
        n_cmp++; if (rd_req !== 2'b00) begin n_err++; $display("FAIL reset_req got %b want 00", rd_req); end
        n_cmp++; if (rd_add !== 64'h0) begin n_err++; $display("FAIL reset_add got %h want 0", rd_add); end
        n_cmp++; if (rd_id !== 12'h0) begin n_err++; $display("FAIL reset_id got %h want 0", rd_id); end
        n_cmp++; if (rd_last !== 2'b00) begin n_err++; $display("FAIL reset_last got %b want 00", rd_last); end
        rst = 1'b0;
    endtask

    task automatic test_incr_full();
        logic [31:0] e0;
        rd_gnt = 2'b11;
        do_ar(6'h05, 32'h1000, 8'd3, 3'd3, 2'b01);
        n_cmp++; if (ar_ready !== 1'b0) begin n_err++; $display("FAIL incr_ar_ready_busy got %b want 0", ar_ready); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            e0 = 32'h1000 + 32'(8 * i);
            n_cmp++; if (rd_req !== 2'b11) begin n_err++; $display("FAIL incr_req beat %0d got %b want 11", i, rd_req); end
            n_cmp++; if (rd_add !== {e0 + 32'd4, e0}) begin n_err++; $display("FAIL incr_add beat %0d got %h want %h", i, rd_add, {e0 + 32'd4, e0}); end
            n_cmp++; if (rd_last !== {2{i == 3}}) begin n_err++; $display("FAIL incr_last beat %0d got %b want %b", i, rd_last, {2{i == 3}}); end
            n_cmp++; if (rd_id !== {6'h05, 6'h05}) begin n_err++; $display("FAIL incr_id beat %0d got %h want 145", i, rd_id); end
        end
        @(negedge clk);
        n_cmp++; if (ar_ready !== 1'b1) begin n_err++; $display("FAIL incr_ar_ready_done got %b want 1", ar_ready); end
        n_cmp++; if (rd_req !== 2'b00) begin n_err++; $display("FAIL incr_req_done got %b want 00", rd_req); end
    endtask

    task automatic test_incr_narrow();
        logic [31:0] exp0 [4] = '{32'h2000, 32'h2008, 32'h2008, 32'h2010};
        rd_gnt = 2'b11;
        do_ar(6'h11, 32'h2004, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (rd_add !== {exp0[i] + 32'd4, exp0[i]} || rd_req !== 2'b11) begin
                n_err++; $display("FAIL narrow_add beat %0d got %h req %b want %h req 11", i, rd_add, rd_req, {exp0[i] + 32'd4, exp0[i]});
            end
            n_cmp++; if (rd_last !== {2{i == 3}}) begin n_err++; $display("FAIL narrow_last beat %0d got %b", i, rd_last); end
        end
        @(negedge clk);
        n_cmp++; if (ar_ready !== 1'b1) begin n_err++; $display("FAIL narrow_ar_ready got %b want 1", ar_ready); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp0 [4] = '{32'h3018, 32'h3000, 32'h3008, 32'h3010};
        rd_gnt = 2'b11;
        do_ar(6'h22, 32'h3018, 8'd3, 3'd3, 2'b10);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (rd_add !== {exp0[i] + 32'd4, exp0[i]} || rd_req !== 2'b11) begin
                n_err++; $display("FAIL wrap_add beat %0d got %h req %b want %h req 11", i, rd_add, rd_req, {exp0[i] + 32'd4, exp0[i]});
            end
            n_cmp++; if (rd_last !== {2{i == 3}}) begin n_err++; $display("FAIL wrap_last beat %0d got %b", i, rd_last); end
        end
        @(negedge clk);
        n_cmp++; if (ar_ready !== 1'b1) begin n_err++; $display("FAIL wrap_ar_ready got %b want 1", ar_ready); end
    endtask

    task automatic test_lane_skew();
        int s0, s1;
        rd_gnt = 2'b01;
        s0 = g0_cnt; s1 = g1_cnt;
        do_ar(6'h33, 32'h6000, 8'd1, 3'd3, 2'b01);
        n_cmp++; if (rd_req !== 2'b11 || rd_add !== {32'h6004, 32'h6000}) begin
            n_err++; $display("FAIL skew_beat0 got req %b add %h want 11 6000600", rd_req, rd_add);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (rd_req !== 2'b10) begin n_err++; $display("FAIL skew_hold_req cyc %0d got %b want 10", i, rd_req); end
            n_cmp++; if (rd_add[1] !== 32'h6004 || rd_last[1] !== 1'b0) begin
                n_err++; $display("FAIL skew_hold_add cyc %0d got %h last %b want 00006004 last 0", i, rd_add[1], rd_last[1]);
            end
            if (i == 2) rd_gnt = 2'b11;
        end
        @(negedge clk);
        n_cmp++; if (rd_req !== 2'b11 || rd_add !== {32'h600C, 32'h6008} || rd_last !== 2'b11) begin
            n_err++; $display("FAIL skew_beat1 got req %b add %h last %b want 11 0000600c00006008 11", rd_req, rd_add, rd_last);
        end
        @(negedge clk);
        n_cmp++; if (ar_ready !== 1'b1 || rd_req !== 2'b00) begin
            n_err++; $display("FAIL skew_done got ready %b req %b want 1 00", ar_ready, rd_req);
        end
        n_cmp++; if (g0_cnt - s0 !== 2 || g1_cnt - s1 !== 2) begin
            n_err++; $display("FAIL skew_grant_count got %0d/%0d want 2/2", g0_cnt - s0, g1_cnt - s1);
        end
    endtask

    task automatic test_fixed_long();
        rd_gnt = 2'b11;
        do_ar(6'h3F, 32'h4000, 8'd255, 3'd3, 2'b00);
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (rd_req !== 2'b11 || rd_add !== {32'h4004, 32'h4000}) begin
                n_err++; $display("FAIL fixed_add beat %0d got req %b add %h", i, rd_req, rd_add);
            end
            n_cmp++; if (rd_last !== {2{i == 255}}) begin n_err++; $display("FAIL fixed_last beat %0d got %b", i, rd_last); end
        end
        @(negedge clk);
        n_cmp++; if (ar_ready !== 1'b1 || rd_req !== 2'b00) begin
            n_err++; $display("FAIL fixed_done got ready %b req %b want 1 00", ar_ready, rd_req);
        end
    endtask

    task automatic test_corner_sizes();
        // Oversized beat clamps to 8 bytes; WRAP with len=2 behaves as INCR.
        rd_gnt = 2'b11;
        do_ar(6'h01, 32'h9000, 8'd1, 3'd5, 2'b01);
        @(negedge clk);
        n_cmp++; if (rd_add !== {32'h900C, 32'h9008}) begin n_err++; $display("FAIL clamp_add got %h want 0000900c00009008", rd_add); end
        @(negedge clk);
        do_ar(6'h02, 32'h8008, 8'd2, 3'd2, 2'b10);
        @(negedge clk);
        n_cmp++; if (rd_add !== {32'h800C, 32'h8008}) begin n_err++; $display("FAIL badwrap_add1 got %h want 0000800c00008008", rd_add); end
        @(negedge clk);
        n_cmp++; if (rd_add !== {32'h8014, 32'h8010} || rd_last !== 2'b11) begin
            n_err++; $display("FAIL badwrap_add2 got %h last %b want 0000801400008010 11", rd_add, rd_last);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int s0;
        rd_gnt = 2'b11;
        do_ar(6'h0A, 32'h7000, 8'd7, 3'd3, 2'b01);
        repeat (2) @(negedge clk);
        n_cmp++; if (rd_add[0] !== 32'h7010) begin n_err++; $display("FAIL midrst_beat2 got %h want 00007010", rd_add[0]); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (rd_req !== 2'b00 || ar_ready !== 1'b1 || rd_last !== 2'b00) begin
            n_err++; $display("FAIL midrst_state got req %b ready %b last %b want 00 1 00", rd_req, ar_ready, rd_last);
        end
        rst = 1'b0;
        s0 = g0_cnt;
        do_ar(6'h0B, 32'h5000, 8'd0, 3'd3, 2'b01);
        n_cmp++; if (rd_req !== 2'b11 || rd_add !== {32'h5004, 32'h5000} || rd_last !== 2'b11 || rd_id !== {6'h0B, 6'h0B}) begin
            n_err++; $display("FAIL midrst_single got req %b add %h last %b id %h", rd_req, rd_add, rd_last, rd_id);
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (ar_ready !== 1'b1 || rd_req !== 2'b00 || g0_cnt - s0 !== 1) begin
            n_err++; $display("FAIL midrst_after got ready %b req %b grants %0d want 1 00 1", ar_ready, rd_req, g0_cnt - s0);
        end
    endtask

    initial begin
        rst = 1'b1; ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0;
        ar_size = '0; ar_burst = '0; rd_gnt = '0;
        test_reset();
        test_incr_full();
        test_incr_narrow();
        test_wrap();
        test_lane_skew();
        test_fixed_long();
        test_corner_sizes();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
